// File: rtl/branch_pc_unit.sv
// branch_pc_unit: PC and flag registers with single-cycle branch resolution.
// Defining RAS_RETURN_STACK_EN adds a circular return-address stack for call/ret.
module branch_pc_unit #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                RAS_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              b,
   input  logic              br,
   input  logic              bz,
   input  logic              bnz,
   input  logic              bcy,
   input  logic              bncy,
   input  logic              bs,
   input  logic              bns,
   input  logic              bv,
   input  logic              bnv,
   input  logic              call,
   input  logic              ret,
   input  logic              flags_we,
   input  logic              alu_zero,
   input  logic              alu_carry,
   input  logic              alu_sign,
   input  logic              alu_ovf,
   input  logic [ADDR_W-1:0] offset,
   input  logic [ADDR_W-1:0] reg_target,
   output logic [ADDR_W-1:0] pc,
   output logic              taken,
   output logic [3:0]        flags,
   output logic              link_we,
   output logic [ADDR_W-1:0] link_addr,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_err
);

   if ((RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("RAS_DEPTH must be a power of two and at least 2");
   end

   logic [ADDR_W-1:0] r_pc;
   logic [3:0]        r_flags;
   logic [ADDR_W-1:0] w_pc_inc;
   logic [ADDR_W-1:0] w_pc_rel;
   logic [ADDR_W-1:0] w_target;
   logic [ADDR_W-1:0] w_ret_target;
   logic              w_take;

   assign w_pc_inc = r_pc + ADDR_W'(1);
   assign w_pc_rel = r_pc + offset;

`ifdef RAS_RETURN_STACK_EN
   localparam int SP_W = $clog2(RAS_DEPTH);
   localparam logic [SP_W-1:0] SP_ONE  = 1;
   localparam logic [SP_W:0]   CNT_ONE = 1;
   localparam logic [SP_W:0]   CNT_DEPTH = RAS_DEPTH[SP_W:0];

   logic [ADDR_W-1:0] r_stack [RAS_DEPTH];
   logic [SP_W-1:0]   r_sp;
   // Counts past RAS_DEPTH after an overflow so the wrapped entry is still popped.
   logic [SP_W:0]     r_cnt;
   logic              r_err;
   logic [SP_W-1:0]   w_top;
   logic              w_empty;
   logic              w_full;
   logic              w_push;
   logic              w_pop;
   logic              w_ret_empty;

   assign w_top        = r_sp - SP_ONE;
   assign w_empty      = (r_cnt == '0);
   assign w_full       = (r_cnt >= CNT_DEPTH);
   assign w_push       = en & call & ~ret;
   assign w_pop        = en & ret & ~w_empty;
   assign w_ret_empty  = en & ret & w_empty;
   assign w_ret_target = w_empty ? RESET_PC : r_stack[w_top];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sp  <= '0;
         r_cnt <= '0;
         r_err <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++) r_stack[i] <= '0;
      end else if (w_push) begin
         r_stack[r_sp] <= w_pc_inc;
         r_sp          <= r_sp + SP_ONE;
         if (r_cnt != '1) r_cnt <= r_cnt + CNT_ONE;
         if (w_full) r_err <= 1'b1;
      end else if (w_pop) begin
         r_sp  <= r_sp - SP_ONE;
         r_cnt <= r_cnt - CNT_ONE;
      end else if (w_ret_empty) begin
         r_err <= 1'b1;
      end
   end

   assign ras_empty = w_empty;
   assign ras_full  = w_full;
   assign ras_err   = r_err;
`else
   assign w_ret_target = reg_target;
   assign ras_empty    = 1'b1;
   assign ras_full     = 1'b0;
   assign ras_err      = 1'b0;
`endif

   // Priority on illegal multi-strobe input: ret > call > br > b > conditionals.
   always_comb begin
      w_take   = 1'b0;
      w_target = w_pc_inc;
      if (ret) begin
         w_take   = 1'b1;
         w_target = w_ret_target;
      end else if (call || (b && !br)) begin
         w_take   = 1'b1;
         w_target = w_pc_rel;
      end else if (br) begin
         w_take   = 1'b1;
         w_target = reg_target;
      end else begin
         if      (bz)   w_take = r_flags[3];
         else if (bnz)  w_take = ~r_flags[3];
         else if (bcy)  w_take = r_flags[2];
         else if (bncy) w_take = ~r_flags[2];
         else if (bs)   w_take = r_flags[1];
         else if (bns)  w_take = ~r_flags[1];
         else if (bv)   w_take = r_flags[0];
         else if (bnv)  w_take = ~r_flags[0];
         if (w_take) w_target = w_pc_rel;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc    <= RESET_PC;
         r_flags <= '0;
      end else if (en) begin
         r_pc <= w_target;
         if (flags_we) r_flags <= {alu_zero, alu_carry, alu_sign, alu_ovf};
      end
   end

   assign pc        = r_pc;
   assign flags     = r_flags;
   assign taken     = en & ~rst & w_take;
   assign link_we   = en & ~rst & call & ~ret;
   assign link_addr = w_pc_inc;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: vector table plus hand-written call/ret/reset sequences.
module tb_branch_pc_unit;
   localparam int W = 32;
`ifdef RAS_RETURN_STACK_EN
   localparam bit HAS_RAS = 1'b1;
`else
   localparam bit HAS_RAS = 1'b0;
`endif

   localparam logic [11:0] SB    = 12'h800;
   localparam logic [11:0] SBR   = 12'h400;
   localparam logic [11:0] SBZ   = 12'h200;
   localparam logic [11:0] SBNZ  = 12'h100;
   localparam logic [11:0] SBCY  = 12'h080;
   localparam logic [11:0] SBNCY = 12'h040;
   localparam logic [11:0] SBS   = 12'h020;
   localparam logic [11:0] SBNS  = 12'h010;
   localparam logic [11:0] SBV   = 12'h008;
   localparam logic [11:0] SBNV  = 12'h004;
   localparam logic [11:0] SCALL = 12'h002;
   localparam logic [11:0] SRET  = 12'h001;

   typedef struct {
      logic [11:0]  s;
      logic         fwe;
      logic [3:0]   alu;
      logic [W-1:0] off;
      logic [W-1:0] tgt;
      logic         e;
      logic         x_taken;
      logic         x_link;
      logic [W-1:0] x_pc;
      logic [3:0]   x_flags;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic [11:0]  strb = '0;
   logic         flags_we = 1'b0;
   logic [3:0]   alu = '0;
   logic [W-1:0] offset = '0;
   logic [W-1:0] reg_target = '0;
   logic [W-1:0] pc, link_addr;
   logic         taken, link_we, ras_empty, ras_full, ras_err;
   logic [3:0]   flags;

   int n_vec = 0;
   int n_err = 0;
   vec_t vt[$];

   always #5 clk = ~clk;

   branch_pc_unit #(.ADDR_W(W), .RESET_PC('0), .RAS_DEPTH(8)) dut (
      .clk(clk), .rst(rst), .en(en),
      .b(strb[11]), .br(strb[10]), .bz(strb[9]), .bnz(strb[8]),
      .bcy(strb[7]), .bncy(strb[6]), .bs(strb[5]), .bns(strb[4]),
      .bv(strb[3]), .bnv(strb[2]), .call(strb[1]), .ret(strb[0]),
      .flags_we(flags_we), .alu_zero(alu[3]), .alu_carry(alu[2]),
      .alu_sign(alu[1]), .alu_ovf(alu[0]),
      .offset(offset), .reg_target(reg_target),
      .pc(pc), .taken(taken), .flags(flags),
      .link_we(link_we), .link_addr(link_addr),
      .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
   );

   function automatic vec_t mk(input logic [11:0] s, input logic fwe, input logic [3:0] a,
                               input logic [W-1:0] off, input logic [W-1:0] tgt, input logic e,
                               input logic xt, input logic xl, input logic [W-1:0] xpc,
                               input logic [3:0] xf);
      vec_t v;
      v.s = s; v.fwe = fwe; v.alu = a; v.off = off; v.tgt = tgt; v.e = e;
      v.x_taken = xt; v.x_link = xl; v.x_pc = xpc; v.x_flags = xf;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [11:0] s, input logic fwe, input logic [3:0] a,
                        input logic [W-1:0] off, input logic [W-1:0] tgt, input logic e);
      @(negedge clk);
      strb = s; flags_we = fwe; alu = a; offset = off; reg_target = tgt; en = e;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet_reset();
      @(negedge clk);
      rst = 1'b1; strb = '0; en = 1'b0; flags_we = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [W-1:0] exp_pc;
      logic [W-1:0] links [1:9];

      // Reset with live strobes: nothing may be taken or advance.
      @(negedge clk);
      rst = 1'b1; en = 1'b1; strb = SB; offset = 32'h8; flags_we = 1'b1; alu = 4'hF;
      tick();
      tick();
      chk("rst taken", taken, 0);
      chk("rst link_we", link_we, 0);
      chk("rst pc", pc, 0);
      chk("rst flags", flags, 0);
      @(negedge clk);
      rst = 1'b0; strb = '0; en = 1'b0; flags_we = 1'b0; alu = '0;
      #1;
      chk("rst ras_empty", ras_empty, 1);
      chk("rst ras_full", ras_full, 0);
      chk("rst ras_err", ras_err, 0);

      vt.push_back(mk(12'h0, 0, 4'h0, 0, 0, 1, 0, 0, 32'd1, 4'h0));
      vt.push_back(mk(12'h0, 0, 4'h0, 0, 0, 1, 0, 0, 32'd2, 4'h0));
      vt.push_back(mk(12'h0, 1, 4'h8, 0, 0, 1, 0, 0, 32'd3, 4'h8));
      vt.push_back(mk(SBZ, 0, 4'h0, 5, 0, 1, 1, 0, 32'd8, 4'h8));
      vt.push_back(mk(SBNZ, 0, 4'h0, 5, 0, 1, 0, 0, 32'd9, 4'h8));
      vt.push_back(mk(SBCY, 1, 4'h4, 7, 0, 1, 0, 0, 32'd10, 4'h4));
      vt.push_back(mk(SBCY, 0, 4'h0, 7, 0, 1, 1, 0, 32'd17, 4'h4));
      vt.push_back(mk(SBNCY, 0, 4'h0, 3, 0, 1, 0, 0, 32'd18, 4'h4));
      vt.push_back(mk(SB, 1, 4'hF, 100, 0, 0, 0, 0, 32'd18, 4'h4));
      vt.push_back(mk(12'h0, 1, 4'h3, 0, 0, 1, 0, 0, 32'd19, 4'h3));
      vt.push_back(mk(SBS, 0, 4'h0, 32'hFFFF_FFFC, 0, 1, 1, 0, 32'd15, 4'h3));
      vt.push_back(mk(SBNS, 0, 4'h0, 9, 0, 1, 0, 0, 32'd16, 4'h3));
      vt.push_back(mk(SBV, 0, 4'h0, 2, 0, 1, 1, 0, 32'd18, 4'h3));
      vt.push_back(mk(SBNV, 0, 4'h0, 2, 0, 1, 0, 0, 32'd19, 4'h3));
      vt.push_back(mk(SBNZ, 0, 4'h0, 1, 0, 1, 1, 0, 32'd20, 4'h3));
      vt.push_back(mk(SBZ, 0, 4'h0, 1, 0, 1, 0, 0, 32'd21, 4'h3));
      vt.push_back(mk(SBCY, 0, 4'h0, 1, 0, 1, 0, 0, 32'd22, 4'h3));
      vt.push_back(mk(SBNCY, 0, 4'h0, 2, 0, 1, 1, 0, 32'd24, 4'h3));
      vt.push_back(mk(SB, 0, 4'h0, 32'hFFFF_FFE8, 0, 1, 1, 0, 32'd0, 4'h3));
      vt.push_back(mk(SBR, 0, 4'h0, 0, 32'h40, 1, 1, 0, 32'h40, 4'h3));
      vt.push_back(mk(SBR | SB, 0, 4'h0, 4, 32'h100, 1, 1, 0, 32'h100, 4'h3));
      vt.push_back(mk(SB | SBZ, 0, 4'h0, 8, 0, 1, 1, 0, 32'h108, 4'h3));
      vt.push_back(mk(SBZ | SBNZ, 0, 4'h0, 8, 0, 1, 0, 0, 32'h109, 4'h3));
      vt.push_back(mk(SCALL, 0, 4'h0, 32'h20, 0, 1, 1, 1, 32'h129, 4'h3));
      vt.push_back(mk(SCALL, 0, 4'h0, 32'h20, 0, 0, 0, 0, 32'h129, 4'h3));
      vt.push_back(mk(SBR, 0, 4'h0, 0, 32'hFFFF_FFFF, 1, 1, 0, 32'hFFFF_FFFF, 4'h3));
      vt.push_back(mk(12'h0, 1, 4'h0, 0, 0, 1, 0, 0, 32'd0, 4'h0));
      vt.push_back(mk(SBR, 0, 4'h0, 0, 32'hFFFF_FFFE, 1, 1, 0, 32'hFFFF_FFFE, 4'h0));
      vt.push_back(mk(SB, 0, 4'h0, 3, 0, 1, 1, 0, 32'd1, 4'h0));
      vt.push_back(mk(SBNS, 0, 4'h0, 2, 0, 1, 1, 0, 32'd3, 4'h0));
      vt.push_back(mk(SBNV, 0, 4'h0, 2, 0, 1, 1, 0, 32'd5, 4'h0));
      vt.push_back(mk(SBV, 0, 4'h0, 2, 0, 1, 0, 0, 32'd6, 4'h0));
      vt.push_back(mk(SBS, 0, 4'h0, 2, 0, 1, 0, 0, 32'd7, 4'h0));
      vt.push_back(mk(SCALL | SBR, 0, 4'h0, 32'h10, 32'h500, 1, 1, 1, 32'h17, 4'h0));

      exp_pc = '0;
      for (int i = 0; i < vt.size(); i++) begin
         drive(vt[i].s, vt[i].fwe, vt[i].alu, vt[i].off, vt[i].tgt, vt[i].e);
         chk($sformatf("v%0d taken", i), taken, vt[i].x_taken);
         chk($sformatf("v%0d link_we", i), link_we, vt[i].x_link);
         if (vt[i].x_link) chk($sformatf("v%0d link_addr", i), link_addr, exp_pc + 1);
         tick();
         chk($sformatf("v%0d pc", i), pc, vt[i].x_pc);
         chk($sformatf("v%0d flags", i), flags, vt[i].x_flags);
         exp_pc = vt[i].x_pc;
      end

      // call then ret returns to call address + 1.
      quiet_reset();
      drive(SBR, 0, 4'h0, 0, 32'd10, 1);
      tick();
      chk("cr pc10", pc, 32'd10);
      drive(SCALL, 0, 4'h0, 32'd20, 32'h55, 1);
      chk("cr call taken", taken, 1);
      chk("cr link_we", link_we, 1);
      chk("cr link_addr", link_addr, 32'd11);
      tick();
      chk("cr pc30", pc, 32'd30);
      chk("cr empty after call", ras_empty, HAS_RAS ? 0 : 1);
      drive(SRET, 0, 4'h0, 0, 32'h55, 1);
      chk("cr ret taken", taken, 1);
      chk("cr ret link_we", link_we, 0);
      tick();
      chk("cr ret pc", pc, HAS_RAS ? 32'd11 : 32'h55);
      chk("cr empty after ret", ras_empty, 1);

      // Nine nested calls overflow an 8-deep stack, then unwind.
      quiet_reset();
      drive(SBR, 0, 4'h0, 0, 32'h100, 1);
      tick();
      for (int k = 1; k <= 9; k++) begin
         links[k] = 32'h100 + 32'h10 * (k - 1) + 1;
         drive(SCALL, 0, 4'h0, 32'h10, 0, 1);
         chk($sformatf("nest link%0d", k), link_addr, links[k]);
         tick();
         if (k == 8) begin
            chk("nest full8", ras_full, HAS_RAS ? 1 : 0);
            chk("nest err8", ras_err, 0);
         end
      end
      chk("nest full9", ras_full, HAS_RAS ? 1 : 0);
      chk("nest err9", ras_err, HAS_RAS ? 1 : 0);
      chk("nest pc", pc, 32'h190);
      for (int j = 1; j <= 9; j++) begin
         drive(SRET, 0, 4'h0, 0, 32'hABC, 1);
         tick();
         chk($sformatf("unwind ret%0d", j), pc,
             HAS_RAS ? ((j <= 8) ? links[10 - j] : links[9]) : 32'hABC);
      end
      chk("unwind empty", ras_empty, 1);
      drive(SRET, 0, 4'h0, 0, 32'hABC, 1);
      tick();
      chk("ret on empty pc", pc, HAS_RAS ? 32'd0 : 32'hABC);
      chk("ret on empty err", ras_err, HAS_RAS ? 1 : 0);

      // Asynchronous reset while a call is pending.
      drive(SBR, 0, 4'h0, 0, 32'h200, 1);
      tick();
      drive(SCALL, 1, 4'hF, 32'h40, 0, 1);
      tick();
      chk("mid pc before", pc, 32'h240);
      @(negedge clk);
      strb = SCALL; en = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      chk("mid rst pc", pc, 32'd0);
      chk("mid rst flags", flags, 4'h0);
      chk("mid rst empty", ras_empty, 1);
      chk("mid rst err", ras_err, 0);
      chk("mid rst taken", taken, 0);
      @(negedge clk);
      rst = 1'b0; strb = '0; en = 1'b0; flags_we = 1'b0;
      drive(SRET, 0, 4'h0, 0, 32'h66, 1);
      tick();
      chk("post rst ret pc", pc, HAS_RAS ? 32'd0 : 32'h66);
      chk("post rst ret err", ras_err, HAS_RAS ? 1 : 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Program-counter and branch-resolution stage directly downstream of the instruction decoder. It consumes the decoder's one-hot branch strobes (b, br, bz … Call, Ret) and the ALU status outputs, holds the architectural flag register and the PC, and resolves every control transfer. It also maintains an optional return-address stack for Call/Ret and drives the PC into instruction fetch.

## Interface
- ADDR_W, 32: PC / address width.
- RESET_PC, 0: PC value loaded on reset.
- RAS_DEPTH, 8: return-address-stack entries (power of two, ≥2).
- clk  in  1: single clock; all state updates on rising edge.
- rst  in  1: reset, asynchronous, active-high.
- en  in  1: advance; when low, PC, flags and RAS hold.
- b, br, bz, bnz, bcy, bncy, bs, bns, bv, bnv, call, ret  in  1 each: decoder branch strobes, at most one high per cycle.
- flags_we  in  1: current instruction updates flags.
- alu_zero, alu_carry, alu_sign, alu_ovf  in  1 each: ALU status of the current instruction.
- offset  in  ADDR_W: sign-extended PC-relative displacement.
- reg_target  in  ADDR_W: register operand for br (and for ret when RAS is compiled out).
- pc  out  ADDR_W: current PC.
- taken  out  1: combinational; transfer taken this cycle.
- flags  out  4: {Z,C,S,V} flag register.
- link_we  out  1 / link_addr  out  ADDR_W: link write request and its value (pc+1).
- ras_empty, ras_full, ras_err  out  1 each: stack status; ras_err is sticky.

## Operation
- Flag register: when en && flags_we, loads {alu_zero, alu_carry, alu_sign, alu_ovf} at the clock edge. Branches read the registered flags, i.e. the flags of the last flag-writing instruction.
- Condition mapping:
  - b, call, ret, br: unconditional.
  - bz/bnz: Z=1 / Z=0.
  - bcy/bncy: C=1 / C=0.
  - bs/bns: S=1 / S=0.
  - bv/bnv: V=1 / V=0.
- Next PC, when en:
  - br: reg_target.
  - ret: RAS top (or reg_target, see Configuration).
  - b, call, or taken conditional: pc + offset, modulo 2^ADDR_W (wraps).
  - Otherwise: pc + 1, also modulo 2^ADDR_W.
- Multiple strobes high in the same cycle is illegal. Priority is then ret > call > br > b > conditionals in listed order; no error flag is raised.
- call: link_addr = pc+1 with link_we=1. With the RAS, pc+1 is also pushed.
- ret with RAS: pops the top entry into pc.
- RAS full + call: push overwrites the oldest entry (circular), ras_err set, ras_full stays 1.
- RAS empty + ret: pc ← RESET_PC, ras_err set, pointer unchanged.
- ras_err clears only on reset.
- en low: taken, link_we forced 0, no state change.

## Timing
- Reset (async assert, sync-safe release):
  - pc=RESET_PC, flags=0.
  - RAS pointer=0, ras_empty=1, ras_full=0, ras_err=0.
  - taken=0, link_we=0.
- Branch latency: decision is combinational in the strobe cycle. New pc is visible one cycle after the strobe edge; no delay slot.
- Flag latency: a flags_we instruction in cycle N affects branches from cycle N+1. A branch in the same cycle as flags_we sees the old flags.
- RAS push/pop take effect at the same edge as the pc update. A call immediately followed by ret returns to the call address+1.
- Reset mid-operation discards the pending transfer and all stack contents.

## Configuration
- RAS_RETURN_STACK_EN defined:
  - Internal RAS_DEPTH stack is present.
  - ret target = stack top.
  - ras_* outputs are live.
- Undefined:
  - No stack storage.
  - call only drives link_we/link_addr; ret target = reg_target.
  - ras_empty=1, ras_full=0, ras_err=0 constant.

## Test plan
- Reset → pc=0, flags=0, ras_empty=1. With en=1 and no strobes, pc steps 0,1,2,3.
- ALU add sets flags_we with zero=1. Next cycle bz, offset=+5 at pc=3 → taken=1, pc=8. bnz under the same flags → pc=pc+1.
- flags_we with carry=1 and bcy in the same cycle, old C=0 → not taken. bcy next cycle → taken.
- pc=10, call offset=+20 → pc=30, link_addr=11. ret → pc=11, ras_empty=1.
- RAS_DEPTH=8: 9 nested calls → ras_err=1, ras_full=1. Then 9 rets: 8 return correct addresses for the newest 8 calls, the last returns to the wrapped (overwritten) entry. ret on empty → pc=RESET_PC.
- pc=0xFFFFFFFF, no strobe → pc=0. br with reg_target=0x40 → pc=0x40. rst pulsed mid-call → pc=0, stack empty.
